// File: rtl/hamming_secded_stream_decoder.sv
// rtl/hamming_secded_stream_decoder.sv - two-stage streaming Hamming SECDED decoder with saturating error counters
module hamming_secded_stream_decoder #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 16,
   localparam int R = (DATA_W <= 4)  ? 3 :
                      (DATA_W <= 11) ? 4 :
                      (DATA_W <= 26) ? 5 :
                      (DATA_W <= 57) ? 6 : 7,
   localparam int N = DATA_W + R + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      code_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              correct_en,
   output logic [DATA_W-1:0] data_out,
   output logic [R-1:0]      err_pos,
   output logic              single_err,
   output logic              double_err,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  single_cnt,
   output logic [CNT_W-1:0]  double_cnt
);

   localparam logic [R:0] MAX_POS = (R+1)'(N - 1);

   logic              s1_valid;
   logic [N-1:1]      s1_code;
   logic [R-1:0]      s1_syn;
   logic              s1_par;
   logic              s1_cen;
   logic              s2_ready;
   logic [R-1:0]      syn;

   logic [N-1:1]      fixed_code;
   logic [DATA_W-1:0] dec_data;
   logic [R-1:0]      dec_pos;
   logic              dec_single;
   logic              dec_double;
   logic              syn_nz;
   logic              in_range;

   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;

   always_comb begin
      syn = '0;
      for (int i = 1; i < N; i++) begin
         for (int j = 0; j < R; j++) begin
            if (((i >> j) & 1) == 1) begin
               syn[j] = syn[j] ^ code_in[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
         s1_cen   <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_code <= code_in[N-1:1];
            s1_syn  <= syn;
            s1_par  <= ^code_in;
            s1_cen  <= correct_en;
         end
      end
   end

   // A syndrome pointing past the last codeword bit cannot be a single error.
   always_comb begin : classify
      int k;
      syn_nz     = |s1_syn;
      in_range   = ({1'b0, s1_syn} <= MAX_POS);
      dec_single = s1_par && (!syn_nz || in_range);
      dec_double = syn_nz && (!s1_par || !in_range);
      dec_pos    = dec_single ? s1_syn : '0;
      fixed_code = s1_code;
      if (dec_single && syn_nz && s1_cen) begin
         fixed_code[s1_syn] = ~fixed_code[s1_syn];
      end
      dec_data = '0;
      k = 0;
      for (int i = 1; i < N; i++) begin
         if ((i & (i - 1)) != 0) begin
            dec_data[k] = fixed_code[i];
            k = k + 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         data_out   <= '0;
         err_pos    <= '0;
         single_err <= 1'b0;
         double_err <= 1'b0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_out   <= dec_data;
            err_pos    <= dec_pos;
            single_err <= dec_single;
            double_err <= dec_double;
         end
      end
   end

   // Statistics count delivered words only, so a stalled word is counted once.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr) begin
         single_cnt <= '0;
         double_cnt <= '0;
      end else if (out_valid && out_ready) begin
         if (single_err && (single_cnt != '1)) begin
            single_cnt <= single_cnt + 1'b1;
         end
         if (double_err && (double_cnt != '1)) begin
            double_cnt <= double_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// tb/tb_hamming_secded_stream_decoder.sv - randomized bench with a position-XOR reference model
module tb_hamming_secded_stream_decoder;
   localparam int DATA_W = 4;
   localparam int CNT_W  = 2;
   localparam int R      = 3;
   localparam int N      = 8;
   localparam int MAXC   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      code_in = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              correct_en = 1'b1;
   logic [DATA_W-1:0] data_out;
   logic [R-1:0]      err_pos;
   logic              single_err;
   logic              double_err;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              cnt_clr = 1'b0;
   logic [CNT_W-1:0]  single_cnt;
   logic [CNT_W-1:0]  double_cnt;

   hamming_secded_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid), .in_ready(in_ready),
      .correct_en(correct_en), .data_out(data_out), .err_pos(err_pos), .single_err(single_err),
      .double_err(double_err), .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
      .single_cnt(single_cnt), .double_cnt(double_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [R-1:0]      pos;
      logic              se;
      logic              de;
   } exp_t;

   exp_t exp_q[$];
   int   m_single = 0;
   int   m_double = 0;
   int   vectors = 0;
   int   miscompares = 0;

   logic              obs_valid;
   logic              obs_in_ready;
   logic [DATA_W-1:0] obs_data;
   logic [R-1:0]      obs_pos;
   logic              obs_se;
   logic              obs_de;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
      logic [N-1:0] cw;
      int k;
      int s;
      cw = '0;
      k = 0;
      s = 0;
      for (int i = 1; i < N; i++) begin
         if ((i & (i - 1)) != 0) begin
            cw[i] = d[k];
            k++;
         end
      end
      for (int i = 1; i < N; i++) if (cw[i]) s = s ^ i;
      for (int j = 0; j < R; j++) cw[1 << j] = s[j];
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic exp_t ref_decode(input logic [N-1:0] c, input logic ce);
      exp_t e;
      int s;
      int p;
      int k;
      logic [N-1:0] f;
      s = 0;
      p = 0;
      f = c;
      for (int i = 0; i < N; i++) begin
         if (c[i]) begin
            p = p ^ 1;
            s = s ^ i;
         end
      end
      e.se = (p == 1) && (s <= N - 1);
      e.de = ((s != 0) && (p == 0)) || ((p == 1) && (s > N - 1));
      if (e.se && s != 0 && ce) f[s] = ~f[s];
      e.pos = e.se ? R'(s) : '0;
      e.d = '0;
      k = 0;
      for (int i = 1; i < N; i++) begin
         if ((i & (i - 1)) != 0) begin
            e.d[k] = f[i];
            k++;
         end
      end
      return e;
   endfunction

   task automatic cycle(input logic v, input logic [N-1:0] c, input logic ce,
                        input logic ordy, input logic clr);
      exp_t e;
      logic in_hs;
      logic out_hs;
      in_valid   = v;
      code_in    = c;
      correct_en = ce;
      out_ready  = ordy;
      cnt_clr    = clr;
      #1;
      obs_valid    = out_valid;
      obs_in_ready = in_ready;
      obs_data     = data_out;
      obs_pos      = err_pos;
      obs_se       = single_err;
      obs_de       = double_err;
      if (exp_q.size() == 0) check("out_valid_idle", out_valid, 1'b0);
      if (out_valid && exp_q.size() > 0) begin
         e = exp_q[0];
         check("data_out", data_out, e.d);
         check("err_pos", err_pos, e.pos);
         check("single_err", single_err, e.se);
         check("double_err", double_err, e.de);
      end
      in_hs  = v && in_ready;
      out_hs = out_valid && ordy;
      if (out_hs && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.se && m_single < MAXC) m_single++;
         if (e.de && m_double < MAXC) m_double++;
      end
      if (clr) begin
         m_single = 0;
         m_double = 0;
      end
      if (in_hs) exp_q.push_back(ref_decode(c, ce));
      @(posedge clk);
      #1;
      check("single_cnt", single_cnt, m_single);
      check("double_cnt", double_cnt, m_double);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      m_single = 0;
      m_double = 0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_data_out", data_out, '0);
      check("rst_err_pos", err_pos, '0);
      check("rst_single_err", single_err, 1'b0);
      check("rst_double_err", double_err, 1'b0);
      check("rst_single_cnt", single_cnt, '0);
      check("rst_double_cnt", double_cnt, '0);
   endtask

   task automatic directed(input string tag, input logic [N-1:0] c, input logic ce,
                           input logic [DATA_W-1:0] d, input logic [R-1:0] pos,
                           input logic se, input logic de);
      cycle(1'b1, c, ce, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check({tag, "_lat1_valid"}, obs_valid, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check({tag, "_valid"}, obs_valid, 1'b1);
      check({tag, "_data"}, obs_data, d);
      check({tag, "_pos"}, obs_pos, pos);
      check({tag, "_single"}, obs_se, se);
      check({tag, "_double"}, obs_de, de);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] d;
      logic [N-1:0]      cw;
      int                nerr;
      int                p1;
      int                p2;

      do_reset();

      directed("clean", 8'hAA, 1'b1, 4'b1011, 3'd0, 1'b0, 1'b0);
      directed("corr", 8'h8A, 1'b1, 4'b1011, 3'd5, 1'b1, 1'b0);
      check("corr_single_cnt", single_cnt, 2'd1);
      directed("detect", 8'h8A, 1'b0, 4'b1001, 3'd5, 1'b1, 1'b0);
      directed("bit0", 8'hAB, 1'b1, 4'b1011, 3'd0, 1'b1, 1'b0);
      directed("dbl", 8'hCA, 1'b1, 4'b1101, 3'd0, 1'b0, 1'b1);
      check("dbl_double_cnt", double_cnt, 2'd1);
      directed("sat4", 8'h8A, 1'b1, 4'b1011, 3'd5, 1'b1, 1'b0);
      directed("sat5", 8'h8A, 1'b1, 4'b1011, 3'd5, 1'b1, 1'b0);
      check("sat_single_cnt", single_cnt, 2'd3);

      cycle(1'b1, 8'h8A, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
      check("clr_hs_valid", obs_valid, 1'b1);
      check("clr_single_cnt", single_cnt, '0);
      check("clr_double_cnt", double_cnt, '0);

      cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      check("bp_w1_ready", obs_in_ready, 1'b1);
      cycle(1'b1, 8'h8A, 1'b0, 1'b0, 1'b0);
      check("bp_w2_ready", obs_in_ready, 1'b1);
      cycle(1'b1, 8'hCA, 1'b1, 1'b0, 1'b0);
      check("bp_w3_blocked", obs_in_ready, 1'b0);
      cycle(1'b1, 8'hCA, 1'b1, 1'b0, 1'b0);
      check("bp_w3_still_blocked", obs_in_ready, 1'b0);
      check("bp_hold_data", obs_data, 4'b1011);
      cycle(1'b1, 8'hCA, 1'b1, 1'b1, 1'b0);
      check("bp_w3_on_release", obs_in_ready, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("bp_w2_data", obs_data, 4'b1001);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("bp_w3_double", obs_de, 1'b1);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("bp_drained", exp_q.size(), 0);

      cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'h8A, 1'b1, 1'b0, 1'b0);
      do_reset();
      repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);

      repeat (600) begin
         d    = DATA_W'($urandom);
         cw   = encode(d);
         nerr = $urandom_range(0, 2);
         p1   = $urandom_range(0, N - 1);
         p2   = (p1 + $urandom_range(1, N - 1)) % N;
         if (nerr >= 1) cw[p1] = ~cw[p1];
         if (nerr == 2) cw[p2] = ~cw[p2];
         cycle($urandom_range(0, 3) != 0, cw, 1'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("final_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
